keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL provide parameter SCAN_DIV, default 200: clock cycles per row slot (min 4).
REQ-002 The block SHALL provide parameter DEBOUNCE_FRAMES, default 4: consecutive identical frames needed to accept a press or release (1..15).
REQ-003 The block SHALL provide parameter REPEAT_FRAMES, default 64: frames between auto-repeat pulses (used only with KEY_REPEAT_EN; 1..255).
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RST_n  input  1  asynchronous, active-low reset.
REQ-006 Col_In  input  4  keypad columns, active-low (pulled up externally), asynchronous to CLK.
REQ-007 Row_Out  output  4  row drive, active-low one-hot.
REQ-008 Key_Code  output  4  code of the accepted key = row*4 + col.
REQ-009 Key_Valid  output  1  one-cycle pulse per accepted press (and per repeat when enabled).
REQ-010 Key_Held  output  1  high while an accepted key is held (PRESSED or RELEASE state).

Function
REQ-011 Col_In SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Slot counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap the row index SHALL advance 0->1->2->3->0; Row_Out = 1110, 1101, 1011, 0111 for rows 0..3.
REQ-013 Synchronized columns SHALL be sampled once per slot, at count SCAN_DIV-1 (settle time of SCAN_DIV-1 cycles after row change).
REQ-014 A frame is 4 slots (rows 0..3); at the row-3 sample the frame result SHALL be: NONE (no column low in any row), SINGLE(code) (exactly one row/column intersection low), or MULTI (anything else).
REQ-015 FSM states IDLE, DEBOUNCE, PRESSED, RELEASE; frame counter 4 bits; all transitions evaluated only at frame end.
REQ-016 IDLE: SINGLE(c) -> DEBOUNCE, candidate=c, count=1; NONE/MULTI -> stay.
REQ-017 DEBOUNCE: SINGLE(candidate) -> count+1; when count+1 = DEBOUNCE_FRAMES -> PRESSED; NONE, MULTI or different code -> IDLE, count=0.
REQ-018 DEBOUNCE_FRAMES=1 SHALL go IDLE -> PRESSED directly on first SINGLE frame.
REQ-019 Entering PRESSED: Key_Code <= candidate and Key_Valid = 1 for exactly the cycle after that frame end; Key_Held = 1.
REQ-020 PRESSED: NONE -> RELEASE, count=1; SINGLE/MULTI of any code -> stay (no new pulse, Key_Code unchanged).
REQ-021 RELEASE: NONE -> count+1; on reaching DEBOUNCE_FRAMES -> IDLE, Key_Held = 0; any non-NONE frame -> PRESSED with no Key_Valid pulse.
REQ-022 Key_Code SHALL hold its last accepted value in all states until the next accepted press.
REQ-023 Scanning SHALL run continuously regardless of FSM state.

Reset
REQ-024 While RST_n = 0: Row_Out = 1110, row index 0, slot counter 0, synchronizer = 1111, Key_Code = 0, Key_Valid = 0, Key_Held = 0, FSM IDLE, frame/repeat counters 0.
REQ-025 Reset asserted mid-press SHALL abandon the press; after release of reset a still-held key SHALL require full debounce and produce one new pulse.

Configuration
REQ-026 Macro KEYPAD_SCANNER_REPEAT_EN defined: in PRESSED, a repeat counter increments each SINGLE(Key_Code) frame; on reaching REPEAT_FRAMES it clears and Key_Valid pulses one cycle; cleared on entering PRESSED or on any other frame result.
REQ-027 Macro undefined: no repeat counter is built; exactly one Key_Valid pulse per accepted press.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2, REPEAT_FRAMES=3; frame = 16 cycles)
REQ-028 Reset then idle columns 1111 -> Row_Out cycles 1110,1101,1011,0111 each for 4 cycles; Key_Valid never pulses, Key_Held = 0.
REQ-029 Column 2 low only while Row_Out=1101, held 5 frames -> single Key_Valid pulse after 2nd frame end, Key_Code = 6, Key_Held = 1; released 2 frames -> Key_Held = 0.
REQ-030 Key 6 for 1 frame, then key 7 for 1 frame, then none -> no Key_Valid pulse; FSM back to IDLE.
REQ-031 Keys 0 and 5 pressed together for 4 frames -> MULTI every frame, no pulse, Key_Code unchanged.
REQ-032 Key 15 accepted, 1 NONE frame (bounce), key 15 again -> Key_Held stays 1, no second pulse.
REQ-033 Repeat enabled, key 3 held 10 frames -> pulses at frame 2 (accept), 5, 8; repeat disabled -> pulse at frame 2 only; RST_n pulsed at frame 6 -> Key_Held = 0 and Key_Code = 0 immediately, new pulse 2 frames after reset release.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle for keypad_scanner: column sense in, row drive and key events out.
interface keypad_scanner_if;
  logic [3:0] Col_In;
  logic [3:0] Row_Out;
  logic [3:0] Key_Code;
  logic       Key_Valid;
  logic       Key_Held;

  modport master (output Col_In, input Row_Out, Key_Code, Key_Valid, Key_Held);
  modport slave  (input Col_In, output Row_Out, Key_Code, Key_Valid, Key_Held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-level debounce.
// Define KEYPAD_SCANNER_REPEAT_EN to build the auto-repeat counter.
module keypad_scanner #(
  parameter int SCAN_DIV        = 200,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 64
) (
  input  logic             CLK,
  input  logic             RST_n,
  keypad_scanner_if.slave  kp
);

  localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  logic [3:0]        col_s1_q, col_s2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [3:0]        acc_code_q, acc_code_d;
  state_t            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
`ifdef KEYPAD_SCANNER_REPEAT_EN
  logic [7:0]        rep_q, rep_d;
`endif

  logic       sample, frame_end;
  logic [2:0] row_lows, tot_lows;
  logic [1:0] row_col;
  logic [3:0] f_code;
  logic       f_none, f_single;

  // State register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      col_s1_q   <= 4'hF;
      col_s2_q   <= 4'hF;
      slot_q     <= '0;
      row_q      <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
      state_q    <= S_IDLE;
      cand_q     <= 4'd0;
      cnt_q      <= 4'd0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rep_q      <= 8'd0;
`endif
    end else begin
      col_s1_q   <= kp.Col_In;
      col_s2_q   <= col_s1_q;
      slot_q     <= slot_d;
      row_q      <= row_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  // Row timing and per-frame accumulation of low intersections
  always_comb begin
    sample    = (slot_q == SLOT_W'(SCAN_DIV - 1));
    frame_end = sample && (row_q == 2'd3);
    slot_d    = sample ? '0 : slot_q + SLOT_W'(1);
    row_d     = sample ? row_q + 2'd1 : row_q;

    row_lows = 3'd0;
    row_col  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!col_s2_q[i]) begin
        row_lows = row_lows + 3'd1;
        row_col  = 2'(i);
      end
    end

    tot_lows = {1'b0, acc_cnt_q} + row_lows;
    f_code   = (row_lows == 3'd1) ? {row_q, row_col} : acc_code_q;
    f_none   = (tot_lows == 3'd0);
    f_single = (tot_lows == 3'd1);

    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (frame_end) begin
      acc_cnt_d  = 2'd0;
      acc_code_d = 4'd0;
    end else if (sample) begin
      // Saturate at 2: anything beyond one intersection is already MULTI
      acc_cnt_d  = (tot_lows >= 3'd2) ? 2'd2 : tot_lows[1:0];
      acc_code_d = f_code;
    end
  end

  // Next-state logic, evaluated only at frame end
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (frame_end) begin
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rep_d = 8'd0;
`endif
      case (state_q)
        S_IDLE: begin
          if (f_single) begin
            cand_d = f_code;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = S_PRESSED;
              code_d  = f_code;
              valid_d = 1'b1;
              cnt_d   = 4'd0;
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end
        end
        S_DEBOUNCE: begin
          if (f_single && (f_code == cand_q)) begin
            if (cnt_q + 4'd1 == 4'(DEBOUNCE_FRAMES)) begin
              state_d = S_PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end
        end
        S_PRESSED: begin
          if (f_none) begin
            // A single release frame already satisfies a 1-frame debounce
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = S_IDLE;
              cnt_d   = 4'd0;
            end else begin
              state_d = S_RELEASE;
              cnt_d   = 4'd1;
            end
          end
`ifdef KEYPAD_SCANNER_REPEAT_EN
          else if (f_single && (f_code == code_q)) begin
            if (rep_q + 8'd1 == 8'(REPEAT_FRAMES)) begin
              rep_d   = 8'd0;
              valid_d = 1'b1;
            end else begin
              rep_d = rep_q + 8'd1;
            end
          end
`endif
        end
        S_RELEASE: begin
          if (f_none) begin
            if (cnt_q + 4'd1 == 4'(DEBOUNCE_FRAMES)) begin
              state_d = S_IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = S_PRESSED;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    kp.Row_Out   = ~(4'b0001 << row_q);
    kp.Key_Code  = code_q;
    kp.Key_Valid = valid_q;
    kp.Key_Held  = (state_q == S_PRESSED) || (state_q == S_RELEASE);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DF = 2;
  localparam int RF = 3;
  localparam int FR = 4 * SD;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  logic [15:0] keys;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int c0;
  logic [3:0] exp_row;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF), .REPEAT_FRAMES(RF)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .kp    (kp)
  );

  // Pressed key at (r,c) pulls column c low whenever row r is driven low
  always_comb begin
    logic [3:0] col;
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.Row_Out[r]) col[c] = 1'b0;
    kp.Col_In = col;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FR) @(negedge CLK);
  endtask

  task automatic push(input logic [3:0] code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Scoreboard: every Key_Valid pulse must match the head expectation
  always @(negedge CLK) begin
    if (RST_n && kp.Key_Valid === 1'b1) begin
      check("pulse_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("pulse at cycle %0d code %0d (expected cycle %0d code %0d)", cyc, kp.Key_Code, e.cyc, e.code);
        check("pulse_code", {28'd0, kp.Key_Code}, {28'd0, e.code});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    keys = 16'h0000;
    repeat (3) @(negedge CLK);
    check("rst_row_out", {28'd0, kp.Row_Out}, 32'hE);
    check("rst_key_code", {28'd0, kp.Key_Code}, 32'h0);
    check("rst_key_valid", {31'd0, kp.Key_Valid}, 32'h0);
    check("rst_key_held", {31'd0, kp.Key_Held}, 32'h0);
    RST_n = 1'b1;

    // Idle scan: each row driven for SD cycles
    for (int j = 1; j <= FR; j++) begin
      @(negedge CLK);
      exp_row = 4'b0001 << ((j / SD) % 4);
      exp_row = ~exp_row;
      check("row_out_seq", {28'd0, kp.Row_Out}, {28'd0, exp_row});
    end
    check("idle_held", {31'd0, kp.Key_Held}, 32'h0);
    $display("idle scan done");

    // Key 6 accepted after two frames, released after two
    c0 = cyc;
    push(4'd6, c0 + 2 * FR);
    keys = 16'h0040;
    frames(5);
    check("k6_held", {31'd0, kp.Key_Held}, 32'h1);
    check("k6_code", {28'd0, kp.Key_Code}, 32'h6);
    keys = 16'h0000;
    frames(1);
    check("k6_release_held", {31'd0, kp.Key_Held}, 32'h1);
    frames(1);
    check("k6_released", {31'd0, kp.Key_Held}, 32'h0);
    check("k6_code_kept", {28'd0, kp.Key_Code}, 32'h6);
    $display("key 6 press/release done");

    // Changing code during debounce aborts
    keys = 16'h0040;
    frames(1);
    keys = 16'h0080;
    frames(1);
    keys = 16'h0000;
    frames(2);
    check("abort_held", {31'd0, kp.Key_Held}, 32'h0);
    check("abort_code", {28'd0, kp.Key_Code}, 32'h6);
    $display("debounce abort done");

    // Two keys together are MULTI
    keys = 16'h0021;
    frames(4);
    check("multi_held", {31'd0, kp.Key_Held}, 32'h0);
    check("multi_code", {28'd0, kp.Key_Code}, 32'h6);
    keys = 16'h0000;
    frames(1);
    $display("multi-key done");

    // Key 15 with a one-frame bounce
    c0 = cyc;
    push(4'd15, c0 + 2 * FR);
    keys = 16'h8000;
    frames(3);
    check("k15_held", {31'd0, kp.Key_Held}, 32'h1);
    check("k15_code", {28'd0, kp.Key_Code}, 32'hF);
    keys = 16'h0000;
    frames(1);
    check("k15_bounce_held", {31'd0, kp.Key_Held}, 32'h1);
    keys = 16'h8000;
    frames(2);
    check("k15_rehold", {31'd0, kp.Key_Held}, 32'h1);
    keys = 16'h0000;
    frames(2);
    check("k15_released", {31'd0, kp.Key_Held}, 32'h0);
    $display("key 15 bounce done");

    // Key 3 held ten frames
    c0 = cyc;
    push(4'd3, c0 + 2 * FR);
`ifdef KEYPAD_SCANNER_REPEAT_EN
    push(4'd3, c0 + 5 * FR);
    push(4'd3, c0 + 8 * FR);
`endif
    keys = 16'h0008;
    frames(10);
    check("k3_held", {31'd0, kp.Key_Held}, 32'h1);
    check("k3_code", {28'd0, kp.Key_Code}, 32'h3);
    check("k3_pulses_seen", sb.size(), 32'd0);
    keys = 16'h0000;
    frames(2);
    check("k3_released", {31'd0, kp.Key_Held}, 32'h0);
    $display("key 3 hold done");

    // Reset in the middle of a press
    c0 = cyc;
    push(4'd3, c0 + 2 * FR);
`ifdef KEYPAD_SCANNER_REPEAT_EN
    push(4'd3, c0 + 5 * FR);
`endif
    keys = 16'h0008;
    frames(6);
    RST_n = 1'b0;
    #1;
    check("midrst_held", {31'd0, kp.Key_Held}, 32'h0);
    check("midrst_code", {28'd0, kp.Key_Code}, 32'h0);
    check("midrst_row", {28'd0, kp.Row_Out}, 32'hE);
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    c0 = cyc;
    push(4'd3, c0 + 2 * FR);
    frames(3);
    check("postrst_held", {31'd0, kp.Key_Held}, 32'h1);
    check("postrst_code", {28'd0, kp.Key_Code}, 32'h3);
    keys = 16'h0000;
    frames(2);
    check("postrst_released", {31'd0, kp.Key_Held}, 32'h0);
    check("all_pulses_seen", sb.size(), 32'd0);
    $display("reset mid-press done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
